// File: rtl/decode_issue_ctrl.sv
// Packet buffer and issue controller between the fetch FIFO and the dual decoder.
// Splits serialising packets into single-slot issues and holds issue behind a commit lock.
module decode_issue_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_mask,
    input  logic [1:0]                 in_serial,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_mask,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       rob_empty_i,
    input  logic                       serial_done_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       lock_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        ST_NORM = 1'b0,
        ST_HALF = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        mem_mask   [DEPTH];
    logic [1:0]        mem_serial [DEPTH];
    logic [DATA_W-1:0] mem_data   [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          lock, lock_nxt;

    logic          empty, push, pop, handshake;
    logic [1:0]    head_mask, head_serial, issue_mask;
    logic          sel_serial, split, drop;

    assign empty       = (count == '0);
    assign head_mask   = mem_mask[rd_ptr];
    assign head_serial = mem_serial[rd_ptr];

    assign in_ready  = (count < CW'(DEPTH)) && !flush_i;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty && !lock && !flush_i && (issue_mask != 2'b00)
                       && (!sel_serial || rob_empty_i);
    assign handshake = out_valid && out_ready;
    // Empty-mask entries are discarded without a handshake; split packets stay for slot 1.
    assign pop       = drop || (handshake && !split);

    assign out_mask = issue_mask;
    assign out_data = mem_data[rd_ptr];
    assign count_o  = count;
    assign lock_o   = lock;

    // Slot selection for the head entry
    always_comb begin
        issue_mask = 2'b00;
        sel_serial = 1'b0;
        split      = 1'b0;
        drop       = 1'b0;
        if (!empty) begin
            if (state == ST_HALF) begin
                issue_mask = 2'b10;
                sel_serial = head_serial[1];
            end else begin
                case (head_mask)
                    2'b00: drop = 1'b1;
                    2'b11: begin
                        if (head_serial == 2'b00) begin
                            issue_mask = 2'b11;
                        end else begin
                            issue_mask = 2'b01;
                            sel_serial = head_serial[0];
                            split      = 1'b1;
                        end
                    end
                    default: begin
                        issue_mask = head_mask;
                        sel_serial = |(head_serial & head_mask);
                    end
                endcase
            end
        end
    end

    // Next state and lock; flush dominates, lock set beats serial_done
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock;
        if (flush_i) begin
            state_nxt = ST_NORM;
            lock_nxt  = 1'b0;
        end else begin
            if (handshake) begin
                if (state == ST_HALF) begin
                    state_nxt = ST_NORM;
                end else if (split) begin
                    state_nxt = ST_HALF;
                end
            end
            if (handshake && sel_serial) begin
                lock_nxt = 1'b1;
            end else if (serial_done_i) begin
                lock_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_NORM;
            lock   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            lock  <= lock_nxt;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Payload storage carries no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_mask[wr_ptr]   <= in_mask;
            mem_serial[wr_ptr] <= in_serial;
            mem_data[wr_ptr]   <= in_data;
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: inputs driven just after negedge, outputs checked #1 later.
module tb_decode_issue_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mask;
    logic [1:0]        in_serial;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_mask;
    logic [DATA_W-1:0] out_data;
    logic              rob_empty_i;
    logic              serial_done_i;
    logic [2:0]        count_o;
    logic              lock_o;

    int checks = 0;
    int errors = 0;

    decode_issue_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
        .in_serial(in_serial), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
        .out_data(out_data), .rob_empty_i(rob_empty_i),
        .serial_done_i(serial_done_i), .count_o(count_o), .lock_o(lock_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [1:0] m, input logic [1:0] s, input int tag);
        in_valid  = v;
        in_mask   = m;
        in_serial = s;
        in_data   = DATA_W'(tag);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
        rob_empty_i = 1'b1; serial_done_i = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 0);
        repeat (3) next_cycle();
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", count_o); end
        checks++; if (lock_o !== 1'b0) begin errors++; $display("FAIL rst_lock: got %b exp 0", lock_o); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_mask !== 2'b00) begin errors++; $display("FAIL rst_out_mask: got %b exp 00", out_mask); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain_wrap();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b11, 2'b00, 16'h10 + i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b exp 1", i, in_ready); end
            next_cycle();
        end
        drive(1'b1, 2'b11, 2'b00, 16'h99);
        #1;
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count: got %0d exp 4", count_o); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b exp 0", in_ready); end
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_mask !== 2'b11 || out_data !== DATA_W'(16'h10 + i))
                begin errors++; $display("FAIL drain%0d: got v=%b m=%b d=%0h exp v=1 m=11 d=%0h", i, out_valid, out_mask, out_data, 16'h10 + i); end
            next_cycle();
        end
        #1;
        checks++; if (count_o !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got c=%0d v=%b exp c=0 v=0", count_o, out_valid); end
        // Streaming push+pop across pointer wrap
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive(1'b1, 2'b11, 2'b00, 16'h100 + i);
            else       drive(1'b0, 2'b00, 2'b00, 0);
            #1;
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || out_mask !== 2'b11 || out_data !== DATA_W'(16'h100 + i - 1) || count_o !== 3'd1)
                    begin errors++; $display("FAIL stream%0d: got v=%b m=%b d=%0h c=%0d exp v=1 m=11 d=%0h c=1", i, out_valid, out_mask, out_data, count_o, 16'h100 + i - 1); end
            end
            next_cycle();
        end
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL stream_end_count: got %0d exp 0", count_o); end
        next_cycle();
    endtask

    task automatic test_serial_rob_wait();
        out_ready = 1'b1; rob_empty_i = 1'b0;
        drive(1'b1, 2'b11, 2'b10, 16'h20);
        next_cycle();
        drive(1'b1, 2'b11, 2'b00, 16'h21);
        #1;
        checks++; if (out_valid !== 1'b1 || out_mask !== 2'b01 || out_data !== DATA_W'(16'h20))
            begin errors++; $display("FAIL s2_slot0: got v=%b m=%b d=%0h exp v=1 m=01 d=20", out_valid, out_mask, out_data); end
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 0);
        #1;
        checks++; if (out_valid !== 1'b0 || out_mask !== 2'b10 || lock_o !== 1'b0 || count_o !== 3'd2)
            begin errors++; $display("FAIL s2_half_wait: got v=%b m=%b l=%b c=%0d exp v=0 m=10 l=0 c=2", out_valid, out_mask, lock_o, count_o); end
        next_cycle();
        rob_empty_i = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_mask !== 2'b10 || out_data !== DATA_W'(16'h20))
            begin errors++; $display("FAIL s2_slot1: got v=%b m=%b d=%0h exp v=1 m=10 d=20", out_valid, out_mask, out_data); end
        next_cycle();
        #1;
        checks++; if (lock_o !== 1'b1 || out_valid !== 1'b0 || count_o !== 3'd1)
            begin errors++; $display("FAIL s2_locked: got l=%b v=%b c=%0d exp l=1 v=0 c=1", lock_o, out_valid, count_o); end
        next_cycle();
        serial_done_i = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL s2_done_cycle: got v=%b exp 0", out_valid); end
        next_cycle();
        serial_done_i = 1'b0;
        #1;
        checks++; if (lock_o !== 1'b0 || out_valid !== 1'b1 || out_mask !== 2'b11 || out_data !== DATA_W'(16'h21))
            begin errors++; $display("FAIL s2_release: got l=%b v=%b m=%b d=%0h exp l=0 v=1 m=11 d=21", lock_o, out_valid, out_mask, out_data); end
        next_cycle();
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL s2_end_count: got %0d exp 0", count_o); end
        next_cycle();
    endtask

    task automatic test_serial_slot0();
        out_ready = 1'b1; rob_empty_i = 1'b1;
        drive(1'b1, 2'b11, 2'b01, 16'h30);
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 0);
        #1;
        checks++; if (out_valid !== 1'b1 || out_mask !== 2'b01 || out_data !== DATA_W'(16'h30))
            begin errors++; $display("FAIL s3_slot0: got v=%b m=%b d=%0h exp v=1 m=01 d=30", out_valid, out_mask, out_data); end
        next_cycle();
        #1;
        checks++; if (lock_o !== 1'b1 || out_valid !== 1'b0 || out_mask !== 2'b10 || count_o !== 3'd1)
            begin errors++; $display("FAIL s3_held: got l=%b v=%b m=%b c=%0d exp l=1 v=0 m=10 c=1", lock_o, out_valid, out_mask, count_o); end
        next_cycle();
        serial_done_i = 1'b1;
        next_cycle();
        serial_done_i = 1'b0;
        #1;
        checks++; if (lock_o !== 1'b0 || out_valid !== 1'b1 || out_mask !== 2'b10 || out_data !== DATA_W'(16'h30))
            begin errors++; $display("FAIL s3_slot1: got l=%b v=%b m=%b d=%0h exp l=0 v=1 m=10 d=30", lock_o, out_valid, out_mask, out_data); end
        next_cycle();
        #1;
        checks++; if (count_o !== 3'd0 || lock_o !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL s3_end: got c=%0d l=%b v=%b exp c=0 l=0 v=0", count_o, lock_o, out_valid); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 2'b00, 16'h40);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 2'b00, 16'h41 + i);
            #1;
            checks++; if (out_valid !== 1'b1 || out_mask !== 2'b01 || out_data !== DATA_W'(16'h40))
                begin errors++; $display("FAIL bp_hold%0d: got v=%b m=%b d=%0h exp v=1 m=01 d=40", i, out_valid, out_mask, out_data); end
            next_cycle();
        end
        drive(1'b0, 2'b00, 2'b00, 0);
        #1;
        checks++; if (count_o !== 3'd4 || in_ready !== 1'b0)
            begin errors++; $display("FAIL bp_full: got c=%0d r=%b exp c=4 r=0", count_o, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_mask !== ((i == 0) ? 2'b01 : 2'b11) || out_data !== DATA_W'(16'h40 + i))
                begin errors++; $display("FAIL bp_drain%0d: got v=%b m=%b d=%0h exp d=%0h", i, out_valid, out_mask, out_data, 16'h40 + i); end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1; rob_empty_i = 1'b1;
        drive(1'b1, 2'b11, 2'b01, 16'h50);
        next_cycle();
        drive(1'b1, 2'b11, 2'b00, 16'h51);
        next_cycle();
        drive(1'b1, 2'b11, 2'b00, 16'h52);
        next_cycle();
        drive(1'b1, 2'b11, 2'b00, 16'h5f);
        flush_i = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || lock_o !== 1'b1 || count_o !== 3'd3)
            begin errors++; $display("FAIL fl_cycle: got v=%b r=%b l=%b c=%0d exp v=0 r=0 l=1 c=3", out_valid, in_ready, lock_o, count_o); end
        next_cycle();
        flush_i = 1'b0;
        drive(1'b1, 2'b11, 2'b00, 16'h60);
        #1;
        checks++; if (count_o !== 3'd0 || lock_o !== 1'b0 || out_valid !== 1'b0 || out_mask !== 2'b00)
            begin errors++; $display("FAIL fl_after: got c=%0d l=%b v=%b m=%b exp c=0 l=0 v=0 m=00", count_o, lock_o, out_valid, out_mask); end
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 0);
        #1;
        checks++; if (out_valid !== 1'b1 || out_mask !== 2'b11 || out_data !== DATA_W'(16'h60) || count_o !== 3'd1)
            begin errors++; $display("FAIL fl_norm: got v=%b m=%b d=%0h c=%0d exp v=1 m=11 d=60 c=1", out_valid, out_mask, out_data, count_o); end
        next_cycle();
    endtask

    task automatic test_drop_and_coincident();
        out_ready = 1'b1; rob_empty_i = 1'b1;
        drive(1'b1, 2'b00, 2'b00, 16'h70);
        next_cycle();
        drive(1'b1, 2'b10, 2'b00, 16'h71);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_silent: got v=%b exp 0", out_valid); end
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 0);
        #1;
        checks++; if (out_valid !== 1'b1 || out_mask !== 2'b10 || out_data !== DATA_W'(16'h71) || count_o !== 3'd1)
            begin errors++; $display("FAIL drop_next: got v=%b m=%b d=%0h c=%0d exp v=1 m=10 d=71 c=1", out_valid, out_mask, out_data, count_o); end
        next_cycle();
        drive(1'b1, 2'b01, 2'b01, 16'h72);
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 0);
        serial_done_i = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_mask !== 2'b01)
            begin errors++; $display("FAIL co_issue: got v=%b m=%b exp v=1 m=01", out_valid, out_mask); end
        next_cycle();
        serial_done_i = 1'b0;
        #1;
        checks++; if (lock_o !== 1'b1 || count_o !== 3'd0)
            begin errors++; $display("FAIL co_lock_wins: got l=%b c=%0d exp l=1 c=0", lock_o, count_o); end
        serial_done_i = 1'b1;
        next_cycle();
        serial_done_i = 1'b0;
        #1;
        checks++; if (lock_o !== 1'b0) begin errors++; $display("FAIL co_clear: got l=%b exp 0", lock_o); end
        next_cycle();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 2'b00, 16'h80);
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL arst: got c=%0d v=%b exp c=0 v=0", count_o, out_valid); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fill_drain_wrap();
        test_serial_rob_wait();
        test_serial_slot0();
        test_backpressure();
        test_flush();
        test_drop_and_coincident();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
